// File: rtl/registers_cntr_mc_if.sv
// Register/control bus for the multi-channel DMA register block.
// master: host side (strobes, data, acks); slave: register block.
interface registers_cntr_mc_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16,
  parameter int CHW   = 1
);
  localparam int MW = (CNT_W > 9) ? CNT_W : 9;

  logic [CHW-1:0]   CH_SEL;
  logic             CONTR_WR;
  logic             WTC_WR;
  logic             ST_DMA;
  logic             SP_DMA;
  logic             CLR_INT;
  logic [MW-1:0]    MID;
  logic [NCH-1:0]   XFER_ACK;
  logic [8:0]       CNTR_O;
  logic [CNT_W-1:0] WTC_O;
  logic [NCH-1:0]   DMAENA;
  logic [NCH-1:0]   DMADIR;
  logic [NCH-1:0]   INTENA;
  logic [NCH-1:0]   PRESET;
  logic             INT;

  modport master (
    output CH_SEL, CONTR_WR, WTC_WR, ST_DMA, SP_DMA, CLR_INT,
    output MID, XFER_ACK,
    input  CNTR_O, WTC_O, DMAENA, DMADIR, INTENA, PRESET, INT
  );

  modport slave (
    input  CH_SEL, CONTR_WR, WTC_WR, ST_DMA, SP_DMA, CLR_INT,
    input  MID, XFER_ACK,
    output CNTR_O, WTC_O, DMAENA, DMADIR, INTENA, PRESET, INT
  );
endinterface

// File: rtl/registers_cntr_mc.sv
// Per-channel DMA control/count registers with IDLE/RUN state and INT.
// Ports: CLK, RESET_ (async low), bus (registers_cntr_mc_if.slave).
module registers_cntr_mc #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16,
  parameter int CHW   = 1
) (
  input  logic                CLK,
  input  logic                RESET_,
  registers_cntr_mc_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_t;

  st_t              r_st     [NCH];
  st_t              w_st_nxt [NCH];
  logic [CNT_W-1:0] r_cnt    [NCH];
  logic [CNT_W-1:0] w_cnt_nxt[NCH];
  logic [NCH-1:0]   r_dir, w_dir_nxt;
  logic [NCH-1:0]   r_inten, w_inten_nxt;
  logic [NCH-1:0]   r_preset, w_preset_nxt;
  logic [NCH-1:0]   r_tc, w_tc_nxt;
  logic [NCH-1:0]   w_set_tc;
  logic [NCH-1:0]   w_sel;
  logic [NCH-1:0]   w_ena;
  logic             r_int;
  logic             w_unused;

  // Out-of-range CH_SEL matches no channel, so strobes become no-ops.
  always_comb begin
    w_sel = '0;
    for (int n = 0; n < NCH; n++)
      w_sel[n] = (int'(bus.CH_SEL) == n);
  end

  always_comb begin
    w_dir_nxt    = r_dir;
    w_inten_nxt  = r_inten;
    w_preset_nxt = r_preset;
    w_tc_nxt     = r_tc;
    w_set_tc     = '0;
    for (int n = 0; n < NCH; n++) begin
      w_st_nxt[n]  = r_st[n];
      w_cnt_nxt[n] = r_cnt[n];
      if (w_sel[n] && bus.CONTR_WR) begin
        w_dir_nxt[n]    = bus.MID[1];
        w_inten_nxt[n]  = bus.MID[2];
        w_preset_nxt[n] = bus.MID[4];
      end
      unique case (r_st[n])
        IDLE: begin
          if (w_sel[n] && bus.WTC_WR)
            w_cnt_nxt[n] = bus.MID[CNT_W-1:0];
          // A coincident stop wins over start.
          if (w_sel[n] && bus.ST_DMA && !bus.SP_DMA) begin
            if (r_cnt[n] != '0)
              w_st_nxt[n] = RUN;
            else
              w_set_tc[n] = 1'b1;
          end
        end
        RUN: begin
          if (bus.XFER_ACK[n] && r_cnt[n] != '0) begin
            w_cnt_nxt[n] = r_cnt[n] - CNT_W'(1);
            if (r_cnt[n] == CNT_W'(1)) begin
              w_st_nxt[n] = IDLE;
              w_set_tc[n] = 1'b1;
            end
          end
          if (w_sel[n] && bus.SP_DMA)
            w_st_nxt[n] = IDLE;
        end
        default: w_st_nxt[n] = IDLE;
      endcase
      // Set after clear: a terminal event beats CLR_INT.
      if (w_sel[n] && bus.CLR_INT)
        w_tc_nxt[n] = 1'b0;
      if (w_set_tc[n])
        w_tc_nxt[n] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      for (int n = 0; n < NCH; n++) begin
        r_st[n]  <= IDLE;
        r_cnt[n] <= '0;
      end
      r_dir    <= '0;
      r_inten  <= '0;
      r_preset <= '0;
      r_tc     <= '0;
      r_int    <= 1'b0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        r_st[n]  <= w_st_nxt[n];
        r_cnt[n] <= w_cnt_nxt[n];
      end
      r_dir    <= w_dir_nxt;
      r_inten  <= w_inten_nxt;
      r_preset <= w_preset_nxt;
      r_tc     <= w_tc_nxt;
      r_int    <= |(r_tc & r_inten);
    end
  end

  always_comb begin
    w_ena = '0;
    for (int n = 0; n < NCH; n++)
      w_ena[n] = (r_st[n] == RUN);
  end

  always_comb begin
    bus.CNTR_O = '0;
    bus.WTC_O  = '0;
    for (int n = 0; n < NCH; n++) begin
      if (w_sel[n]) begin
        bus.CNTR_O = {w_ena[n], 3'b000, r_preset[n], 1'b0,
                      r_inten[n], r_dir[n], r_tc[n]};
        bus.WTC_O  = r_cnt[n];
      end
    end
  end

  assign bus.DMAENA = w_ena;
  assign bus.DMADIR = r_dir;
  assign bus.INTENA = r_inten;
  assign bus.PRESET = r_preset;
  assign bus.INT    = r_int;

  // MID is wider than the fields taken from it for small CNT_W.
  assign w_unused = ^bus.MID;

endmodule

// File: tb/tb_registers_cntr_mc.sv
// Directed bench for registers_cntr_mc (NCH=2, CNT_W=16, CHW=2).
// Tasks per scenario, inline checks, one summary line.
module tb_registers_cntr_mc;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  registers_cntr_mc_if #(.NCH(2), .CNT_W(16), .CHW(2)) bus ();

  registers_cntr_mc #(.NCH(2), .CNT_W(16), .CHW(2)) dut (
    .CLK    (clk),
    .RESET_ (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    bus.CONTR_WR = 1'b0;
    bus.WTC_WR   = 1'b0;
    bus.ST_DMA   = 1'b0;
    bus.SP_DMA   = 1'b0;
    bus.CLR_INT  = 1'b0;
    bus.XFER_ACK = '0;
    bus.MID      = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.CH_SEL = '0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      bus.CH_SEL = 2'(c);
      #1;
      checks++;
      if (bus.CNTR_O !== 9'h000) begin
        errors++;
        $display("FAIL reset_cntr ch%0d: got %h exp 000", c, bus.CNTR_O);
      end
      checks++;
      if (bus.WTC_O !== 16'd0) begin
        errors++;
        $display("FAIL reset_wtc ch%0d: got %0d exp 0", c, bus.WTC_O);
      end
    end
    checks++;
    if (bus.INT !== 1'b0 || bus.DMAENA !== 2'b00) begin
      errors++;
      $display("FAIL reset_int_ena: got %b/%b exp 0/00", bus.INT, bus.DMAENA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_terminal_count();
    bus.CH_SEL = 2'd1;
    bus.WTC_WR = 1'b1;
    bus.MID    = 16'd3;
    step();
    bus.CONTR_WR = 1'b1;
    bus.MID      = 16'h004;
    step();
    checks++;
    if (bus.CNTR_O !== 9'h004 || bus.WTC_O !== 16'd3) begin
      errors++;
      $display("FAIL tc_setup: got %h/%0d exp 004/3", bus.CNTR_O, bus.WTC_O);
    end
    bus.ST_DMA = 1'b1;
    step();
    checks++;
    if (bus.DMAENA !== 2'b10) begin
      errors++;
      $display("FAIL tc_start: got %b exp 10", bus.DMAENA);
    end
    bus.XFER_ACK = 2'b10;
    step();
    bus.XFER_ACK = 2'b10;
    step();
    checks++;
    if (bus.WTC_O !== 16'd1 || bus.DMAENA !== 2'b10) begin
      errors++;
      $display("FAIL tc_two_acks: got %0d/%b exp 1/10", bus.WTC_O, bus.DMAENA);
    end
    bus.XFER_ACK = 2'b10;
    step();
    checks++;
    if (bus.DMAENA !== 2'b00 || bus.CNTR_O !== 9'h005) begin
      errors++;
      $display("FAIL tc_done: got %b/%h exp 00/005", bus.DMAENA, bus.CNTR_O);
    end
    checks++;
    if (bus.INT !== 1'b0 || bus.WTC_O !== 16'd0) begin
      errors++;
      $display("FAIL tc_int_lag: got %b/%0d exp 0/0", bus.INT, bus.WTC_O);
    end
    step();
    checks++;
    if (bus.INT !== 1'b1) begin
      errors++;
      $display("FAIL tc_int: got %b exp 1", bus.INT);
    end
    bus.XFER_ACK = 2'b10;
    step();
    checks++;
    if (bus.WTC_O !== 16'd0) begin
      errors++;
      $display("FAIL tc_idle_ack: got %0d exp 0", bus.WTC_O);
    end
    bus.CLR_INT = 1'b1;
    step();
    checks++;
    if (bus.CNTR_O !== 9'h004) begin
      errors++;
      $display("FAIL clr_tc: got %h exp 004", bus.CNTR_O);
    end
    step();
    checks++;
    if (bus.INT !== 1'b0) begin
      errors++;
      $display("FAIL clr_int: got %b exp 0", bus.INT);
    end
  endtask

  task automatic test_run_stop();
    bus.CH_SEL = 2'd0;
    bus.WTC_WR = 1'b1;
    bus.MID    = 16'd5;
    step();
    bus.ST_DMA = 1'b1;
    step();
    bus.WTC_WR = 1'b1;
    bus.MID    = 16'd9;
    step();
    checks++;
    if (bus.WTC_O !== 16'd5 || bus.DMAENA !== 2'b01) begin
      errors++;
      $display("FAIL run_wtc_lock: got %0d/%b exp 5/01", bus.WTC_O, bus.DMAENA);
    end
    bus.XFER_ACK = 2'b01;
    step();
    bus.XFER_ACK = 2'b01;
    step();
    bus.SP_DMA = 1'b1;
    step();
    checks++;
    if (bus.DMAENA !== 2'b00 || bus.WTC_O !== 16'd3) begin
      errors++;
      $display("FAIL run_stop: got %b/%0d exp 00/3", bus.DMAENA, bus.WTC_O);
    end
    checks++;
    if (bus.CNTR_O !== 9'h000) begin
      errors++;
      $display("FAIL run_stop_tc: got %h exp 000", bus.CNTR_O);
    end
    bus.CH_SEL = 2'd1;
    #1;
    checks++;
    if (bus.WTC_O !== 16'd0 || bus.CNTR_O !== 9'h004) begin
      errors++;
      $display("FAIL run_isolate: got %0d/%h exp 0/004", bus.WTC_O, bus.CNTR_O);
    end
  endtask

  task automatic test_start_stop();
    bus.CH_SEL = 2'd0;
    bus.ST_DMA = 1'b1;
    bus.SP_DMA = 1'b1;
    step();
    checks++;
    if (bus.DMAENA !== 2'b00 || bus.WTC_O !== 16'd3) begin
      errors++;
      $display("FAIL st_sp_same: got %b/%0d exp 00/3", bus.DMAENA, bus.WTC_O);
    end
    bus.CH_SEL = 2'd1;
    bus.ST_DMA = 1'b1;
    step();
    checks++;
    if (bus.DMAENA !== 2'b00 || bus.CNTR_O !== 9'h005) begin
      errors++;
      $display("FAIL st_zero: got %b/%h exp 00/005", bus.DMAENA, bus.CNTR_O);
    end
    bus.CLR_INT = 1'b1;
    step();
    step();
  endtask

  task automatic test_clr_collide();
    bus.CH_SEL = 2'd0;
    bus.ST_DMA = 1'b1;
    step();
    bus.XFER_ACK = 2'b01;
    step();
    bus.XFER_ACK = 2'b01;
    step();
    bus.XFER_ACK = 2'b01;
    bus.CLR_INT  = 1'b1;
    step();
    checks++;
    if (bus.CNTR_O !== 9'h001 || bus.DMAENA !== 2'b00) begin
      errors++;
      $display("FAIL clr_collide: got %h/%b exp 001/00", bus.CNTR_O, bus.DMAENA);
    end
    bus.CH_SEL = 2'd3;
    #1;
    checks++;
    if (bus.CNTR_O !== 9'h000 || bus.WTC_O !== 16'd0) begin
      errors++;
      $display("FAIL oor_read: got %h/%0d exp 000/0", bus.CNTR_O, bus.WTC_O);
    end
    bus.WTC_WR   = 1'b1;
    bus.CONTR_WR = 1'b1;
    bus.CLR_INT  = 1'b1;
    bus.MID      = 16'h0016;
    step();
    bus.ST_DMA = 1'b1;
    step();
    checks++;
    if (bus.INTENA !== 2'b10 || bus.DMADIR !== 2'b00 ||
        bus.PRESET !== 2'b00 || bus.DMAENA !== 2'b00) begin
      errors++;
      $display("FAIL oor_ctrl: got %b %b %b %b exp 10 00 00 00",
               bus.INTENA, bus.DMADIR, bus.PRESET, bus.DMAENA);
    end
    bus.CH_SEL = 2'd0;
    #1;
    checks++;
    if (bus.CNTR_O !== 9'h001 || bus.WTC_O !== 16'd0) begin
      errors++;
      $display("FAIL oor_ch0: got %h/%0d exp 001/0", bus.CNTR_O, bus.WTC_O);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.CH_SEL   = 2'd0;
    bus.CONTR_WR = 1'b1;
    bus.MID      = 16'h0014;
    step();
    bus.CH_SEL = 2'd1;
    bus.WTC_WR = 1'b1;
    bus.MID    = 16'd4;
    step();
    bus.ST_DMA = 1'b1;
    step();
    checks++;
    if (bus.DMAENA !== 2'b10 || bus.INT !== 1'b1 || bus.WTC_O !== 16'd4) begin
      errors++;
      $display("FAIL pre_reset: got %b/%b/%0d exp 10/1/4",
               bus.DMAENA, bus.INT, bus.WTC_O);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.DMAENA !== 2'b00 || bus.INT !== 1'b0 ||
        bus.CNTR_O !== 9'h000 || bus.WTC_O !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got %b/%b/%h/%0d exp 00/0/000/0",
               bus.DMAENA, bus.INT, bus.CNTR_O, bus.WTC_O);
    end
    bus.CH_SEL = 2'd0;
    #1;
    checks++;
    if (bus.CNTR_O !== 9'h000 || bus.INTENA !== 2'b00 ||
        bus.PRESET !== 2'b00) begin
      errors++;
      $display("FAIL reset_ch0: got %h/%b/%b exp 000/00/00",
               bus.CNTR_O, bus.INTENA, bus.PRESET);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.CH_SEL = 2'd1;
    bus.WTC_WR = 1'b1;
    bus.MID    = 16'd2;
    step();
    checks++;
    if (bus.WTC_O !== 16'd2 || bus.CNTR_O !== 9'h000) begin
      errors++;
      $display("FAIL post_reset: got %0d/%h exp 2/000", bus.WTC_O, bus.CNTR_O);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_terminal_count();
    test_run_stop();
    test_start_stop();
    test_clr_collide();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
